// File: rtl/stream_pkg.sv
// Shared stream definitions: default widths, a clog2 helper and the FIRE(v,r) handshake macro.
`ifndef STREAM_PKG_SV
`define STREAM_PKG_SV
`define FIRE(v, r) ((v) & (r))

package stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/stream_fifo.sv
// Synchronous FIFO, DATA_WIDTH x DEPTH; a write appears on rd_data the cycle after the edge.
// A write at full is taken only when a read on the same edge frees the slot.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int PTR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous read and write leaves occupancy unchanged.
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_splitter.sv
// Fans one valid/ready stream out to two per-branch FIFOs; one cycle input-to-output latency.
// Default stalls the input while either FIFO is full; STREAM_SPLITTER_DROP_EN never stalls and counts dropped beats.
module stream_splitter
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_i_tdata,
  input  logic                  data_i_tvalid,
  output logic                  data_i_tready,
  output logic [DATA_WIDTH-1:0] data_0_o_tdata,
  output logic                  data_0_o_tvalid,
  input  logic                  data_0_o_tready,
  output logic [DATA_WIDTH-1:0] data_1_o_tdata,
  output logic                  data_1_o_tvalid,
  input  logic                  data_1_o_tready,
  output logic [CNT_WIDTH-1:0]  drop_count_o
);

  logic full_0;
  logic full_1;
  logic empty_0;
  logic empty_1;
  logic wr_0;
  logic wr_1;

  assign data_0_o_tvalid = ~empty_0;
  assign data_1_o_tvalid = ~empty_1;

`ifdef STREAM_SPLITTER_DROP_EN
  logic                 in_fire;
  logic                 rd_0;
  logic                 rd_1;
  logic                 drop;
  logic [CNT_WIDTH-1:0] drop_count;

  assign data_i_tready = resetn;
  assign in_fire       = `FIRE(data_i_tvalid, data_i_tready);
  assign rd_0          = `FIRE(data_0_o_tvalid, data_0_o_tready);
  assign rd_1          = `FIRE(data_1_o_tvalid, data_1_o_tready);
  // A full branch still takes the beat if it is being read on the same edge.
  assign wr_0          = in_fire & (~full_0 | rd_0);
  assign wr_1          = in_fire & (~full_1 | rd_1);
  assign drop          = in_fire & ~(wr_0 & wr_1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  assign drop_count_o = drop_count;
`else
  // Depends only on registered FIFO state, so no o_tready reaches data_i_tready.
  assign data_i_tready = resetn & ~full_0 & ~full_1;
  assign wr_0          = `FIRE(data_i_tvalid, data_i_tready);
  assign wr_1          = wr_0;
  assign drop_count_o  = '0;
`endif

  stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo_0 (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_0),
    .wr_data (data_i_tdata),
    .rd_en   (data_0_o_tready),
    .rd_data (data_0_o_tdata),
    .full    (full_0),
    .empty   (empty_0)
  );

  stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo_1 (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_1),
    .wr_data (data_i_tdata),
    .rd_en   (data_1_o_tready),
    .rd_data (data_1_o_tdata),
    .full    (full_1),
    .empty   (empty_1)
  );

endmodule

// File: tb/tb_stream_splitter.sv
// Scoreboard bench for stream_splitter: stimulus pushes hand-computed expected beats per branch,
// a negedge monitor pops and compares on every output handshake.
module tb_stream_splitter;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] data_i_tdata = '0;
  logic          data_i_tvalid = 1'b0;
  logic          data_i_tready;
  logic [DW-1:0] data_0_o_tdata;
  logic          data_0_o_tvalid;
  logic          data_0_o_tready = 1'b1;
  logic [DW-1:0] data_1_o_tdata;
  logic          data_1_o_tvalid;
  logic          data_1_o_tready = 1'b1;
  logic [CW-1:0] drop_count_o;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  stream_splitter #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_i_tdata    (data_i_tdata),
    .data_i_tvalid   (data_i_tvalid),
    .data_i_tready   (data_i_tready),
    .data_0_o_tdata  (data_0_o_tdata),
    .data_0_o_tvalid (data_0_o_tvalid),
    .data_0_o_tready (data_0_o_tready),
    .data_1_o_tdata  (data_1_o_tdata),
    .data_1_o_tvalid (data_1_o_tvalid),
    .data_1_o_tready (data_1_o_tready),
    .drop_count_o    (drop_count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of its branch queue.
  always @(negedge clk) begin
    if (resetn) begin
      if (data_0_o_tvalid && data_0_o_tready) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out0_unexpected: got %0h expected no beat", data_0_o_tdata);
        end else begin
          check("out0_data", 32'(data_0_o_tdata), 32'(q0.pop_front()));
        end
      end
      if (data_1_o_tvalid && data_1_o_tready) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out1_unexpected: got %0h expected no beat", data_1_o_tdata);
        end else begin
          check("out1_data", 32'(data_1_o_tdata), 32'(q1.pop_front()));
        end
      end
    end
  end

  // Presents one beat for up to max_wait cycles; p0/p1 say which branches must receive it.
  task automatic send(input logic [DW-1:0] d, input bit p0, input bit p1,
                      input int max_wait, input bit exp_acc, input string name);
    bit acc;
    acc           = 1'b0;
    data_i_tdata  = d;
    data_i_tvalid = 1'b1;
    for (int c = 0; c < max_wait && !acc; c++) begin
      @(negedge clk);
      if (data_i_tready) begin
        acc = 1'b1;
        if (p0) q0.push_back(d);
        if (p1) q1.push_back(d);
      end
      @(posedge clk);
      #1;
    end
    check(name, 32'(acc), 32'(exp_acc));
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done          = 1'b0;
    data_i_tvalid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      done = (q0.size() == 0) && (q1.size() == 0) && !data_0_o_tvalid && !data_1_o_tvalid;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    // T1: reset held with valid input
    resetn        = 1'b0;
    data_i_tvalid = 1'b1;
    data_i_tdata  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tready", 32'(data_i_tready), 32'd0);
    end
    check("rst_vld0", 32'(data_0_o_tvalid), 32'd0);
    check("rst_vld1", 32'(data_1_o_tvalid), 32'd0);
    check("rst_drop", 32'(drop_count_o), 32'd0);
    check("rst_dat0", 32'(data_0_o_tdata), 32'd0);
    check("rst_dat1", 32'(data_1_o_tdata), 32'd0);
    @(posedge clk);
    #1;
    data_i_tvalid = 1'b0;
    resetn        = 1'b1;

    // T2: pass-through, visible one cycle after acceptance
    send(16'hFFFD, 1, 1, 3, 1, "t2_acc");
    check("t2_lat_vld0", 32'({data_0_o_tvalid, data_0_o_tdata}), 32'h1FFFD);
    check("t2_lat_vld1", 32'({data_1_o_tvalid, data_1_o_tdata}), 32'h1FFFD);
    send(16'h0007, 1, 1, 3, 1, "t2_acc");
    check("t2_lat_vld0", 32'({data_0_o_tvalid, data_0_o_tdata}), 32'h10007);
    send(16'h7FFF, 1, 1, 3, 1, "t2_acc");
    check("t2_lat_vld1", 32'({data_1_o_tvalid, data_1_o_tdata}), 32'h17FFF);
    wait_drain("t2_drain");

    data_0_o_tready = 1'b1;
    data_1_o_tready = 1'b0;
`ifndef STREAM_SPLITTER_DROP_EN
    // T3: branch 1 stalled, input backpressured after 4 beats
    for (int i = 0; i < 4; i++) send(16'(16'h0100 + i), 1, 1, 2, 1, "t3_acc");
    check("t3_tready_full", 32'(data_i_tready), 32'd0);
    send(16'h0104, 1, 1, 6, 0, "t3_stalled");
    check("t3_q0_got_4", 32'(q0.size()), 32'd0);
    data_1_o_tready = 1'b1;
    for (int i = 4; i < 10; i++) send(16'(16'h0100 + i), 1, 1, 4, 1, "t3_acc");
    wait_drain("t3_drain");

    // T5: branch 0 full and read on the same edge; branch 1 full so no write
    data_0_o_tready = 1'b0;
    data_1_o_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(16'h0200 + i), 1, 1, 2, 1, "t5_fill");
    data_0_o_tready = 1'b1;
    data_i_tdata    = 16'h02AA;
    data_i_tvalid   = 1'b1;
    @(negedge clk);
    check("t5_tready", 32'(data_i_tready), 32'd0);
    @(posedge clk);
    #1;
    check("t5_tready_after", 32'(data_i_tready), 32'd0);
    data_1_o_tready = 1'b1;
    send(16'h02AA, 1, 1, 4, 1, "t5_late_acc");
    wait_drain("t5_drain");
`else
    // T4: branch 1 stalled in drop mode, 6 beats skipped by branch 1
    for (int i = 0; i < 10; i++) send(16'(16'h0100 + i), 1, (i < 4), 2, 1, "t4_acc");
    check("t4_drop_count", 32'(drop_count_o), 32'd6);
    data_1_o_tready = 1'b1;
    wait_drain("t4_drain");

    // T5: both full and read on the same edge as a write: no drop
    data_0_o_tready = 1'b0;
    data_1_o_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(16'h0200 + i), 1, 1, 2, 1, "t5_fill");
    check("t5_drop_before", 32'(drop_count_o), 32'd6);
    data_0_o_tready = 1'b1;
    data_1_o_tready = 1'b1;
    send(16'h02AA, 1, 1, 2, 1, "t5_acc");
    check("t5_drop_after", 32'(drop_count_o), 32'd6);
    wait_drain("t5_drain");
`endif

    // T6: reset with 3 beats buffered discards them
    data_0_o_tready = 1'b0;
    data_1_o_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'(16'h0300 + i), 1, 1, 2, 1, "t6_fill");
    data_i_tvalid = 1'b0;
    resetn        = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    q0.delete();
    q1.delete();
    check("t6_vld0", 32'(data_0_o_tvalid), 32'd0);
    check("t6_vld1", 32'(data_1_o_tvalid), 32'd0);
    check("t6_drop", 32'(drop_count_o), 32'd0);
    data_0_o_tready = 1'b1;
    data_1_o_tready = 1'b1;
    send(16'h0A5A, 1, 1, 3, 1, "t6_new");
    send(16'h8000, 1, 1, 3, 1, "t6_new");
    wait_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
